// File: rtl/md_sequencer_if.sv
// EX-stage M-extension handshake bundle: operation request from EX, stall/done/result back.
// The master drives the request side and the slave (md_sequencer) drives the status side.
interface md_sequencer_if #(
  parameter int XLEN = 32
);
  logic            MdStartE;
  logic [2:0]      funct3E;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic            FlushE;
  logic            MdStallE;
  logic            MdDoneE;
  logic [XLEN-1:0] MdResultE;

  modport master (
    output MdStartE, funct3E, SrcAE, SrcBE, FlushE,
    input  MdStallE, MdDoneE, MdResultE
  );

  modport slave (
    input  MdStartE, funct3E, SrcAE, SrcBE, FlushE,
    output MdStallE, MdDoneE, MdResultE
  );
endinterface

// File: rtl/md_sequencer.sv
// Iterative RV32M sequencer: radix-2 shift-add multiply / restoring divide, 33-cycle latency (1 for special cases).
// Stalls EX while busy, presents the result for one DONE cycle; MD_DIV_EN builds the divider.
module md_sequencer #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          reset,
  md_sequencer_if.slave md
);
  localparam int W = XLEN;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state;
  logic [5:0]     cnt;
  logic [2:0]     op;
  logic [W-1:0]   opnd;
  logic [2*W-1:0] acc;
  logic           neg_res;
  logic [W-1:0]   result;
  logic           done;
`ifdef MD_DIV_EN
  logic           neg_rem;
`endif

  // Start-time decode: signedness, magnitudes, special cases
  logic         a_signed, b_signed, s_a, s_b;
  logic [W-1:0] a_abs, b_abs;
  logic         special;
  logic [W-1:0] special_res;

  always_comb begin
    a_signed    = md.funct3E[2] ? ~md.funct3E[0] : (md.funct3E[1:0] != 2'b11);
    b_signed    = md.funct3E[2] ? ~md.funct3E[0] : ~md.funct3E[1];
    s_a         = a_signed & md.SrcAE[W-1];
    s_b         = b_signed & md.SrcBE[W-1];
    a_abs       = s_a ? -md.SrcAE : md.SrcAE;
    b_abs       = s_b ? -md.SrcBE : md.SrcBE;
    special     = 1'b0;
    special_res = '0;
`ifdef MD_DIV_EN
    if (md.funct3E[2] && md.SrcBE == '0) begin
      special     = 1'b1;
      special_res = md.funct3E[1] ? md.SrcAE : '1;
    end else if (md.funct3E[2] && !md.funct3E[0] &&
                 md.SrcAE == 32'h8000_0000 && md.SrcBE == 32'hFFFF_FFFF) begin
      special     = 1'b1;
      special_res = md.funct3E[1] ? '0 : 32'h8000_0000;
    end
`else
    special = md.funct3E[2];
`endif
  end

  // One iteration. Multiply: acc = {partial_hi, multiplier}, opnd = multiplicand.
  // Divide: acc = {remainder, dividend/quotient}, opnd = divisor.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] acc_next;
  logic [2*W-1:0] prod;
  logic [W-1:0]   final_res;
`ifdef MD_DIV_EN
  logic [W:0]     div_diff;
  logic [W-1:0]   quo, rem;
`endif

  always_comb begin
    mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
    acc_next = {mul_sum, acc[W-1:1]};
`ifdef MD_DIV_EN
    div_diff = acc[2*W-1:W-1] - {1'b0, opnd};
    if (op[2]) begin
      acc_next = div_diff[W] ? {acc[2*W-2:0], 1'b0}
                             : {div_diff[W-1:0], acc[W-2:0], 1'b1};
    end
`endif
    prod = neg_res ? -acc_next : acc_next;
`ifdef MD_DIV_EN
    quo       = neg_res ? -acc_next[W-1:0] : acc_next[W-1:0];
    rem       = neg_rem ? -acc_next[2*W-1:W] : acc_next[2*W-1:W];
    final_res = op[2] ? (op[1] ? rem : quo)
                      : ((op[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W]);
`else
    final_res = op[2] ? '0 : ((op[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W]);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      op      <= '0;
      opnd    <= '0;
      acc     <= '0;
      neg_res <= 1'b0;
`ifdef MD_DIV_EN
      neg_rem <= 1'b0;
`endif
      result  <= '0;
      done    <= 1'b0;
    end else if (md.FlushE) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (md.MdStartE) begin
            op      <= md.funct3E;
            opnd    <= md.funct3E[2] ? b_abs : a_abs;
            acc     <= {{W{1'b0}}, (md.funct3E[2] ? a_abs : b_abs)};
            neg_res <= s_a ^ s_b;
`ifdef MD_DIV_EN
            neg_rem <= s_a;
`endif
            cnt     <= '0;
            if (special) begin
              result <= special_res;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            result <= final_res;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          // Start is still the finishing instruction here; never re-launch from DONE.
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign md.MdStallE  = ((state == IDLE) && md.MdStartE) || (state == CALC);
  assign md.MdDoneE   = done;
  assign md.MdResultE = result;
endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: table of M-ops with hand-computed results plus flush/reset/back-to-back sequences.
// Divide expectations follow MD_DIV_EN (without it every funct3[2] op finishes in 1 cycle with 0).
module tb_md_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  md_sequencer_if mif ();
  md_sequencer dut (.clk(clk), .reset(reset), .md(mif));

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];
  int   nvec;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
    vecs[nvec] = '{f, a, b, exp, lat};
    nvec++;
  endtask

  // Divide ops: full result when the divider exists, else the 1-cycle zero path.
  task automatic add_div(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
`ifdef MD_DIV_EN
    add_vec(f, a, b, exp, lat);
`else
    add_vec(f, a, b, 32'h0, lat - lat + 1);
`endif
  endtask

  // Called just after a rising edge with the sequencer IDLE. Returns one cycle after DONE
  // (sequencer IDLE again) with MdStartE still high so a following op can go back-to-back.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int stalls);
    mif.MdStartE = 1'b1;
    mif.funct3E  = f;
    mif.SrcAE    = a;
    mif.SrcBE    = b;
    res    = 32'hxxxx_xxxx;
    lat    = -1;
    stalls = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (mif.MdStallE) stalls++;
      if (mif.MdDoneE) begin
        lat = c;
        res = mif.MdResultE;
        break;
      end
      @(posedge clk);
      #1;
      if (c == 0) begin
        // late forwarding changes must not disturb the sampled operands
        mif.SrcAE = ~a;
        mif.SrcBE = a ^ b;
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [31:0] res;
  int          lat, stalls;

  initial begin
    nvec          = 0;
    reset         = 1'b1;
    mif.MdStartE  = 1'b0;
    mif.funct3E   = 3'b000;
    mif.SrcAE     = '0;
    mif.SrcBE     = '0;
    mif.FlushE    = 1'b0;

    add_vec(3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33); // MUL 7*-3
    add_vec(3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33); // MULH
    add_vec(3'b011, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33); // MULHU
    add_vec(3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33); // MULHSU -1*(2^32-1)
    add_vec(3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33); // MULHU max*max
    add_vec(3'b000, 32'd12345,      32'd1000,      32'h00BC_5EA8, 33); // MUL 12345000
    add_div(3'b100, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, 33); // DIV -20/3
    add_div(3'b110, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 33); // REM -20%3
    add_div(3'b101, 32'd100,        32'd7,         32'd14,        33); // DIVU
    add_div(3'b111, 32'd100,        32'd7,         32'd2,         33); // REMU
    add_div(3'b100, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33); // DIV 7/-2
    add_div(3'b110, 32'd7,          32'hFFFF_FFFE, 32'd1,         33); // REM 7%-2
    add_div(3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);  // DIVU by zero
    add_div(3'b110, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 1);  // REM by zero
    add_div(3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);  // REM overflow
    add_div(3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);  // DIV overflow

    // Reset state
    #2;
    check("rst_stall", {31'd0, mif.MdStallE}, 32'd0);
    check("rst_done", {31'd0, mif.MdDoneE}, 32'd0);
    check("rst_result", mif.MdResultE, 32'd0);
    mif.MdStartE = 1'b1;
    #1;
    check("rst_stall_start", {31'd0, mif.MdStallE}, 32'd1);
    mif.MdStartE = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < nvec; i++) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, res, lat, stalls);
      check($sformatf("v%0d_result", i), res, vecs[i].exp);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_stalls", i), stalls, vecs[i].lat);
      mif.MdStartE = 1'b0;
      #1;
      check($sformatf("v%0d_idle_after", i), {30'd0, mif.MdStallE, mif.MdDoneE}, 32'd0);
    end

    // Back-to-back: second op presented in the IDLE cycle right after DONE
    run_op(3'b000, 32'd6, 32'd7, res, lat, stalls);
    check("b2b_first", res, 32'd42);
    run_op(3'b000, 32'hFFFF_FFFF, 32'd5, res, lat, stalls);
    check("b2b_second", res, 32'hFFFF_FFFB);
    check("b2b_second_lat", lat, 33);
    mif.MdStartE = 1'b0;
    #1;

    // Flush at CALC cycle 10 (start seen at cycle 0, cnt=10 at cycle 11)
    mif.MdStartE = 1'b1;
    mif.funct3E  = 3'b000;
    mif.SrcAE    = 32'd9;
    mif.SrcBE    = 32'd9;
    for (int c = 0; c < 11; c++) begin
      @(posedge clk);
      #1;
    end
    mif.FlushE = 1'b1;
    @(posedge clk);
    #1;
    mif.FlushE   = 1'b0;
    mif.MdStartE = 1'b0;
    #1;
    check("flush_stall", {31'd0, mif.MdStallE}, 32'd0);
    check("flush_done", {31'd0, mif.MdDoneE}, 32'd0);
    begin
      int seen = 0;
      for (int c = 0; c < 30; c++) begin
        @(posedge clk);
        #1;
        if (mif.MdDoneE || mif.MdStallE) seen++;
      end
      check("flush_quiet", seen, 0);
    end
    run_op(3'b000, 32'd6, 32'd7, res, lat, stalls);
    check("after_flush_mul", res, 32'd42);
    mif.MdStartE = 1'b0;
    #1;

    // Flush wins over a simultaneous start in IDLE
    mif.MdStartE = 1'b1;
    mif.FlushE   = 1'b1;
    @(posedge clk);
    #1;
    mif.MdStartE = 1'b0;
    mif.FlushE   = 1'b0;
    #1;
    check("flush_start_stall", {31'd0, mif.MdStallE}, 32'd0);
    @(posedge clk);
    #1;
    check("flush_start_done", {31'd0, mif.MdDoneE}, 32'd0);

    // Asynchronous reset in the middle of an operation
    mif.MdStartE = 1'b1;
    mif.funct3E  = 3'b100;
    mif.SrcAE    = 32'hFFFF_FFEC;
    mif.SrcBE    = 32'd3;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
    end
    mif.MdStartE = 1'b0;
    reset        = 1'b1;
    #1;
    check("midrst_stall", {31'd0, mif.MdStallE}, 32'd0);
    check("midrst_done", {31'd0, mif.MdDoneE}, 32'd0);
    check("midrst_result", mif.MdResultE, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_op(3'b011, 32'h0001_0000, 32'h0003_0000, res, lat, stalls);
    check("post_rst_mulhu", res, 32'd3);
    check("post_rst_lat", lat, 33);
    mif.MdStartE = 1'b0;
    @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/md_sequencer.md
# md_sequencer

Iterative sequencer for RV32M multiply/divide in the Execute stage. It accepts an M-extension operation from EX, runs a radix-2 shift-add multiply or restoring divide over 32 cycles, and stalls the pipeline meanwhile. It presents a 32-bit result for one cycle so the instruction can advance into Memory. It works alongside the hazard unit, which ORs `MdStallE` into its stall/flush equations.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; only 32 is supported.

Ports:
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high reset.
- `MdStartE` input 1: the EX-stage instruction is an M-extension op. Held high while the instruction sits in EX.
- `funct3E` input 3: operation select. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `SrcAE` input 32: rs1 operand after forwarding.
- `SrcBE` input 32: rs2 operand after forwarding, never the immediate.
- `FlushE` input 1: synchronous abort of the EX instruction.
- `MdStallE` output 1: hold F/D/E registers and bubble M.
- `MdDoneE` output 1: `MdResultE` is valid this cycle.
- `MdResultE` output 32: operation result.

## Operation
- States:
  - IDLE: the default state.
  - CALC: iterating; a 6-bit counter runs 0..31.
  - DONE: the result is presented.
- IDLE with `MdStartE`=1 and `FlushE`=0:
  - latch `funct3E`, the operand magnitudes and the sign flags;
  - on a special case, load the result and go to DONE;
  - otherwise clear the counter and go to CALC.
- CALC: one iteration per cycle. After iteration 31, apply the sign fix-up, register the result and go to DONE.
- DONE: always returns to IDLE next cycle. `MdStartE` is ignored in DONE because it still belongs to the finishing instruction.
- `MdStallE` = (IDLE & `MdStartE`) | CALC. It is combinational, and low in DONE so the instruction advances.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU/DIVU/REMU: both unsigned.
- The core operates on unsigned magnitudes:
  - product sign = sA^sB;
  - quotient sign = sA^sB;
  - remainder sign = sA.
- MUL returns product[31:0]. MULH/MULHSU/MULHU return product[63:32] of the sign-corrected 64-bit product.
- Special cases, which skip CALC:
  - divide by zero: quotient = 32'hFFFF_FFFF, remainder = SrcAE;
  - signed overflow (DIV/REM with A=32'h8000_0000, B=32'hFFFF_FFFF): quotient = 32'h8000_0000, remainder = 0.
- `FlushE`=1 in any state: next state IDLE, with no result and no done. Flush wins over a simultaneous start.
- Reset mid-operation: immediately IDLE, counter 0, result register 0.

## Timing
- Reset values: state IDLE, `MdStallE`=0 (unless `MdStartE`=1), `MdDoneE`=0, `MdResultE`=0.
- Normal op latency: start seen at cycle 0, CALC at cycles 1–32, DONE at cycle 33. `MdStallE` is high for 33 cycles and `MdDoneE` for exactly 1.
- Special case: start at cycle 0 (stalled), DONE at cycle 1.
- `MdResultE` is registered. It holds its last value outside DONE; consumers must qualify it with `MdDoneE`.
- Back-to-back M ops: the second op's start is seen in the IDLE cycle after DONE, so there are no lost or duplicate operations.
- Operands are sampled only on the IDLE→CALC/DONE edge. Later forwarding changes on `SrcAE`/`SrcBE` have no effect.

## Configuration
- `MD_DIV_EN` defined:
  - the full divider is built;
  - funct3[2]=1 ops behave as above.
- `MD_DIV_EN` undefined:
  - the divider datapath is removed;
  - funct3[2]=1 ops take the special path (start → DONE in 1 cycle) with `MdResultE`=0;
  - multiply ops are unchanged.

## Test plan
- MUL A=7, B=-3 → `MdStallE` high 33 cycles, `MdDoneE` on cycle 33, result 32'hFFFF_FFEB.
- MULH A=32'h8000_0000, B=32'h8000_0000 → result 32'h4000_0000. MULHU with the same operands → 32'h4000_0000. MULHSU A=-1, B=32'hFFFF_FFFF → 32'hFFFF_FFFF.
- DIV A=-20, B=3 → result 32'hFFFF_FFFA (-6). REM with the same operands → 32'hFFFF_FFFE (-2). DIVU A=100, B=7 → 14.
- DIVU A=5, B=0 → done on cycle 1, result 32'hFFFF_FFFF. REM A=32'h8000_0000, B=-1 → done on cycle 1, result 0.
- `FlushE` at CALC cycle 10 → IDLE next cycle, `MdStallE`/`MdDoneE` low. A new MUL 6×7 started afterwards → 42.
- `reset` asserted mid-DIV → all outputs 0 immediately, and normal operation resumes after release.
